// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, write-port FSM states and the pixel-pair word packing helper.
package fb_pkg;

   localparam int H_RES          = 640;
   localparam int V_RES          = 480;
   localparam int WORDS_PER_LINE = 320;
   localparam int FB_WORDS       = WORDS_PER_LINE * V_RES;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } fb_wr_state_t;

   // Both pixels of a word get the same colour, which gives the 2-px trail width.
   function automatic logic [15:0] pack_word(input logic [3:0] color);
      return {4'h0, color, 4'h0, color};
   endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps a pixel coordinate to its packed frame-buffer word address and flags whether it is visible.
module fb_addr_calc #(
   parameter int H_RES = fb_pkg::H_RES,
   parameter int V_RES = fb_pkg::V_RES
) (
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   output logic [18:0] address,
   output logic        on_screen
);

   logic [18:0] y_ext;
   logic [18:0] x_word;

   assign y_ext  = {9'd0, y};
   assign x_word = {10'd0, x[9:1]};

   // y*320 as two shifts: y*256 + y*64.
   assign address   = (y_ext << 8) + (y_ext << 6) + x_word;
   assign on_screen = (x < 10'(H_RES)) && (y < 10'(V_RES));

endmodule

// File: rtl/fb_write_arbiter.sv
// Sole owner of the frameRAM write port: round-robin between the two trail writers,
// plus a one-word-per-cycle full-screen clear engine that pre-empts both.
module fb_write_arbiter #(
   parameter int H_RES    = fb_pkg::H_RES,
   parameter int V_RES    = fb_pkg::V_RES,
   parameter int FB_WORDS = (H_RES / 2) * V_RES
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        clear_start,
   input  logic [3:0]  clear_color,
   input  logic        blue_req,
   input  logic [9:0]  blue_X,
   input  logic [9:0]  blue_Y,
   input  logic [3:0]  blue_color,
   output logic        blue_ack,
   input  logic        red_req,
   input  logic [9:0]  red_X,
   input  logic [9:0]  red_Y,
   input  logic [3:0]  red_color,
   output logic        red_ack,
   output logic [18:0] write_address,
   output logic [15:0] wr_data,
   output logic        WE,
   output logic        clear_busy,
   output logic        clear_done,
   output logic        drop_err
);
   import fb_pkg::*;

   localparam logic [18:0] CLEAR_END = 19'(FB_WORDS);

   fb_wr_state_t state, state_nxt;
   logic [18:0]  counter, counter_nxt;
   logic         rr_red, rr_red_nxt;
   logic         blue_ack_nxt, red_ack_nxt, we_nxt;
   logic [18:0]  addr_nxt;
   logic [15:0]  data_nxt;
   logic         busy_nxt, done_nxt, drop_nxt;
   logic         blue_elig, red_elig, grant_blue, grant_red;
   logic [18:0]  blue_addr, red_addr;
   logic         blue_on, red_on;

   fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_blue_addr (
      .x         (blue_X),
      .y         (blue_Y),
      .address   (blue_addr),
      .on_screen (blue_on)
   );

   fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_red_addr (
      .x         (red_X),
      .y         (red_Y),
      .address   (red_addr),
      .on_screen (red_on)
   );

   // A requester whose ack is already out is still holding req from the last grant.
   assign blue_elig = blue_req & ~blue_ack;
   assign red_elig  = red_req & ~red_ack;

   always_comb begin
      state_nxt    = state;
      counter_nxt  = counter;
      rr_red_nxt   = rr_red;
      blue_ack_nxt = 1'b0;
      red_ack_nxt  = 1'b0;
      we_nxt       = 1'b0;
      addr_nxt     = write_address;
      data_nxt     = wr_data;
      busy_nxt     = clear_busy;
      done_nxt     = 1'b0;
      drop_nxt     = drop_err;
      grant_blue   = 1'b0;
      grant_red    = 1'b0;

      case (state)
         IDLE: begin
            if (clear_start) begin
               state_nxt   = CLEAR;
               counter_nxt = 19'd1;
               we_nxt      = 1'b1;
               addr_nxt    = 19'd0;
               data_nxt    = pack_word(clear_color);
               busy_nxt    = 1'b1;
            end else begin
               grant_blue = blue_elig & (~red_elig | ~rr_red);
               grant_red  = red_elig & (~blue_elig | rr_red);
               if (blue_elig && red_elig)
                  rr_red_nxt = grant_blue;

               if (grant_blue) begin
                  blue_ack_nxt = 1'b1;
                  if (blue_on) begin
                     we_nxt   = 1'b1;
                     addr_nxt = blue_addr;
                     data_nxt = pack_word(blue_color);
                  end else begin
                     drop_nxt = 1'b1;
                  end
               end else if (grant_red) begin
                  red_ack_nxt = 1'b1;
                  if (red_on) begin
                     we_nxt   = 1'b1;
                     addr_nxt = red_addr;
                     data_nxt = pack_word(red_color);
                  end else begin
                     drop_nxt = 1'b1;
                  end
               end
            end
         end

         CLEAR: begin
            // counter is the next word to write; reaching FB_WORDS means the last word is out.
            if (counter == CLEAR_END) begin
               state_nxt   = IDLE;
               counter_nxt = 19'd0;
               busy_nxt    = 1'b0;
               done_nxt    = 1'b1;
            end else begin
               we_nxt      = 1'b1;
               addr_nxt    = counter;
               data_nxt    = pack_word(clear_color);
               counter_nxt = counter + 19'd1;
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state         <= IDLE;
         counter       <= 19'd0;
         rr_red        <= 1'b0;
         blue_ack      <= 1'b0;
         red_ack       <= 1'b0;
         WE            <= 1'b0;
         write_address <= 19'd0;
         wr_data       <= 16'd0;
         clear_busy    <= 1'b0;
         clear_done    <= 1'b0;
         drop_err      <= 1'b0;
      end else begin
         state         <= state_nxt;
         counter       <= counter_nxt;
         rr_red        <= rr_red_nxt;
         blue_ack      <= blue_ack_nxt;
         red_ack       <= red_ack_nxt;
         WE            <= we_nxt;
         write_address <= addr_nxt;
         wr_data       <= data_nxt;
         clear_busy    <= busy_nxt;
         clear_done    <= done_nxt;
         drop_err      <= drop_nxt;
      end
   end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Sole owner of the frameRAM write port (write_address, Data_In, WE).
- Shares the port between the blue trail writer, the red trail writer and an internal full-screen clear engine.
- Converts pixel (X,Y) requests into packed word writes: two 4-bit pixels per 16-bit word, nibbles at [3:0] and [11:8], 320 words per line.
- Sits between the game logic and the frame buffer; the read side (VGA scan) is untouched.

Parameters:
- H_RES, 640, visible pixels per line
- V_RES, 480, visible lines
- FB_WORDS, 153600, frame buffer words (H_RES/2 * V_RES)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- clear_start  in  1  single-cycle pulse; starts a full-screen clear
- clear_color  in  4  colour enum written by the clear
- blue_req  in  1  blue trail write request; held until blue_ack
- blue_X, blue_Y  in  10 each  blue pixel coordinate
- blue_color  in  4  blue colour enum
- blue_ack  out  1  one-cycle acknowledge
- red_req, red_X, red_Y, red_color, red_ack  same as blue
- write_address  out  19  frameRAM word address
- wr_data  out  16  frameRAM write data
- WE  out  1  frameRAM write enable
- clear_busy  out  1  high while the clear is running
- clear_done  out  1  one-cycle pulse when the clear completes
- drop_err  out  1  sticky; set when an off-screen request is dropped

Behaviour:
- Reset values (asynchronous): state IDLE; all outputs 0; clear counter 0; RR pointer = blue.
- All outputs are registered.
- States:
  - IDLE: arbitrate the bike requests.
  - CLEAR: write one word per cycle.
- Transitions:
  - IDLE -> CLEAR on clear_start. clear_start has priority over any bike request in the same cycle.
  - CLEAR -> IDLE after the word at address FB_WORDS-1 is written.
  - clear_start while in CLEAR is ignored; the counter does not restart.
- CLEAR:
  - Each cycle: write_address = counter, wr_data = {4'h0,clear_color,4'h0,clear_color}, WE = 1.
  - The counter increments 0..153599.
  - clear_busy is high from the first clear write through the last.
  - clear_done pulses in the cycle after the last write, together with WE = 0.
  - Total clear duration is exactly FB_WORDS cycles of WE.
  - Bike requests are held, never acked, while busy.
- IDLE arbitration:
  - Eligible = req high AND that requester's ack is not high this cycle. This prevents a double grant on a held req.
  - One eligible requester: grant it.
  - Both eligible: grant the RR pointer; the pointer then moves to the other requester.
  - The pointer updates only when both requesters competed.
- Grant latency: req sampled at edge k. At the same edge the registered ack = 1, write_address, wr_data and WE = 1 all appear (visible in cycle k+1).
- Address: (Y<<8)+(Y<<6)+(X>>1), 19-bit unsigned, no overflow for legal input.
- Data: {4'h0,color,4'h0,color}. Both pixels of the word are written (trail width 2 px).
- Off-screen (X >= H_RES or Y >= V_RES):
  - Request is acked normally, with WE = 0 and the address unchanged.
  - drop_err is set; it clears only on Reset.
- No grant: WE = 0; write_address and wr_data hold their previous values.
- Throughput: at most one write per cycle. A single requester gets at most one write every 2 cycles.
- Reset mid-clear: immediately IDLE, WE = 0, counter 0, clear_busy = 0, no clear_done pulse.

Decomposition:
- Shared package fb_pkg:
  - constants H_RES, V_RES, WORDS_PER_LINE = 320, FB_WORDS
  - typedef enum {IDLE, CLEAR} fb_wr_state_t
  - function pack_word(color) -> 16-bit word
- Sub-module fb_addr_calc: combinational (X,Y) -> {address[18:0], on_screen}. Instantiated once per requester; also reusable by the read side.

Test Plan:
- Reset, then blue_req with X=5, Y=2, color=4'hE held -> exactly one blue_ack; write_address=642, wr_data=16'h0E0E, WE pulse 1 cycle after req.
- Both reqs held continuously, blue (0,0,4'hE), red (10,0,4'h6) -> grants alternate blue, red, blue, red; WE high every cycle; addresses alternate 0 and 5.
- clear_start with clear_color=4'h0 -> exactly 153600 WE cycles with addresses 0..153599 ascending; clear_done pulses once after address 153599; a blue_req raised mid-clear is acked only after clear_done.
- red_req with X=640, Y=0 -> red_ack pulses, WE stays 0, drop_err = 1 and remains 1 after later legal writes.
- Reset asserted at clear counter = 1000 -> outputs zero immediately; after release no writes occur until the next clear_start, which restarts at address 0.
- clear_start and blue_req asserted in the same cycle -> clear starts first; blue is served after clear_done at its computed address.
